// File: rtl/agc_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// agc_sequencer_if : measurement, gain-table and radio write bundle | rev 1.0
// ---------------------------------------------------------------------------
interface agc_sequencer_if;
  logic       sample_valid;
  logic [7:0] rssi_in;
  logic [7:0] pwr_in;
  logic       freeze;
  logic [6:0] gain_in;
  logic       table_en;
  logic [7:0] rssi_avg;
  logic [7:0] pwr_avg;
  logic       gain_wr_req;
  logic [6:0] gain_wr_data;
  logic       gain_wr_ack;
  logic       settling;

  modport master (
    output sample_valid, rssi_in, pwr_in, freeze, gain_in, gain_wr_ack,
    input  table_en, rssi_avg, pwr_avg, gain_wr_req, gain_wr_data, settling
  );

  modport slave (
    input  sample_valid, rssi_in, pwr_in, freeze, gain_in, gain_wr_ack,
    output table_en, rssi_avg, pwr_avg, gain_wr_req, gain_wr_data, settling
  );
endinterface
`default_nettype wire

// File: rtl/agc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// agc_sequencer : windowed RSSI/power averaging, gain-table strobe, gain write
//                 handshake and post-write settle blanking       | rev 1.0
// ---------------------------------------------------------------------------
module agc_sequencer #(
  parameter int         AVG_LOG2      = 3,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         SETTLE_W      = 8,
  parameter logic [6:0] INIT_GAIN     = 7'h7F
) (
  input  logic            clk,
  input  logic            reset,
  agc_sequencer_if.slave  bus
);

  localparam int                  SUM_W         = 8 + AVG_LOG2;
  localparam logic [SETTLE_W-1:0] C_SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ACCUM  = 3'd0,
    S_EVAL   = 3'd1,
    S_CHECK  = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SUM_W-1:0]    r_rssi_sum;
  logic [SUM_W-1:0]    r_pwr_sum;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [7:0]          r_rssi_avg;
  logic [7:0]          r_pwr_avg;
  logic                r_req;
  logic [6:0]          r_data;
  logic [6:0]          r_last_gain;
  logic [SETTLE_W-1:0] r_settle_cnt;

  logic [SUM_W-1:0]    w_rssi_sum_nx;
  logic [SUM_W-1:0]    w_pwr_sum_nx;
  logic                w_win_done;
  logic                w_gain_diff;
  logic                w_settle_done;
  logic                w_table_en;
  logic                w_settling;

  assign w_rssi_sum_nx = r_rssi_sum + SUM_W'(bus.rssi_in);
  assign w_pwr_sum_nx  = r_pwr_sum  + SUM_W'(bus.pwr_in);
  // The window closes on the sample that brings the count to 2^AVG_LOG2.
  assign w_win_done    = (r_state == S_ACCUM) && bus.sample_valid && (&r_cnt);
  assign w_gain_diff   = (bus.gain_in != r_last_gain);
  assign w_settle_done = (r_settle_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WRITE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_table_en = 1'b0;
    w_settling = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (w_win_done && !bus.freeze) begin
          w_next = S_EVAL;
        end
      end
      S_EVAL: begin
        w_table_en = 1'b1;
        w_next     = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_gain_diff ? S_WRITE : S_ACCUM;
      end
      S_WRITE: begin
        if (bus.gain_wr_ack) begin
          w_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_settling = 1'b1;
        if (w_settle_done) begin
          w_next = S_ACCUM;
        end
      end
      default: begin
        w_next = S_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rssi_sum   <= '0;
      r_pwr_sum    <= '0;
      r_cnt        <= '0;
      r_rssi_avg   <= '0;
      r_pwr_avg    <= '0;
      r_req        <= 1'b1;
      r_data       <= INIT_GAIN;
      r_last_gain  <= INIT_GAIN;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (bus.sample_valid) begin
            if (&r_cnt) begin
              r_rssi_avg <= 8'(w_rssi_sum_nx >> AVG_LOG2);
              r_pwr_avg  <= 8'(w_pwr_sum_nx >> AVG_LOG2);
              r_rssi_sum <= '0;
              r_pwr_sum  <= '0;
              r_cnt      <= '0;
            end else begin
              r_rssi_sum <= w_rssi_sum_nx;
              r_pwr_sum  <= w_pwr_sum_nx;
              r_cnt      <= r_cnt + AVG_LOG2'(1);
            end
          end
        end
        S_CHECK: begin
          if (w_gain_diff) begin
            r_data <= bus.gain_in;
            r_req  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.gain_wr_ack) begin
            r_last_gain  <= r_data;
            r_req        <= 1'b0;
            r_settle_cnt <= C_SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_rssi_sum <= '0;
            r_pwr_sum  <= '0;
            r_cnt      <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.table_en     = w_table_en;
  assign bus.settling     = w_settling;
  assign bus.rssi_avg     = r_rssi_avg;
  assign bus.pwr_avg      = r_pwr_avg;
  assign bus.gain_wr_req  = r_req;
  assign bus.gain_wr_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_agc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_agc_sequencer : directed stimulus with event scoreboard      | rev 1.0
// ---------------------------------------------------------------------------
module tb_agc_sequencer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  agc_sequencer_if bus();

  agc_sequencer #(
    .AVG_LOG2      (3),
    .SETTLE_CYCLES (64),
    .SETTLE_W      (8),
    .INIT_GAIN     (7'h7F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_TBL = 0, EV_WR = 1, EV_SET = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       a;
    int       b;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  settle_run = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic void push(input ev_kind_t k, input int a, input int b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input ev_kind_t k, input int a, input int b);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got unexpected kind=%0d a=%0d b=%0d, expected none", k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d",
                 k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: table strobes, completed writes and settle intervals.
  always @(negedge clk) begin
    if (bus.table_en === 1'b1) pop_cmp(EV_TBL, int'(bus.rssi_avg), int'(bus.pwr_avg));
    if (bus.gain_wr_req === 1'b1 && bus.gain_wr_ack === 1'b1)
      pop_cmp(EV_WR, int'(bus.gain_wr_data), 0);
    if (bus.settling === 1'b1) begin
      settle_run++;
    end else if (settle_run != 0) begin
      pop_cmp(EV_SET, settle_run, 0);
      settle_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int r, input int p);
    bus.sample_valid = 1'b1;
    bus.rssi_in      = 8'(r);
    bus.pwr_in       = 8'(p);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic window(input int r, input int p);
    for (int i = 0; i < 8; i++) sample(r, p);
  endtask

  task automatic wait_settle_done(input string name);
    int i;
    i = 0;
    while (bus.settling !== 1'b1 && i < 200) begin tick(); i++; end
    while (bus.settling !== 1'b0 && i < 200) begin tick(); i++; end
    if (i >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles, expected settle to end", name, i);
    end
  endtask

  task automatic wait_req(input string name);
    int i;
    i = 0;
    while (bus.gain_wr_req !== 1'b1 && i < 20) begin tick(); i++; end
    if (i >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no req after %0d cycles, expected req", name, i);
    end
  endtask

  task automatic ack_pulse();
    bus.gain_wr_ack = 1'b1;
    tick();
    bus.gain_wr_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.rssi_in      = '0;
    bus.pwr_in       = '0;
    bus.freeze       = 1'b0;
    bus.gain_in      = 7'h7F;
    bus.gain_wr_ack  = 1'b0;
    tick();
    tick();
    check("rst_req",      int'(bus.gain_wr_req),  1);
    check("rst_data",     int'(bus.gain_wr_data), 'h7F);
    check("rst_table_en", int'(bus.table_en),     0);
    check("rst_settling", int'(bus.settling),     0);
    check("rst_rssi_avg", int'(bus.rssi_avg),     0);
    check("rst_pwr_avg",  int'(bus.pwr_avg),      0);

    // Initial write of the reset gain, acked after 5 cycles.
    push(EV_WR, 'h7F, 0);
    push(EV_SET, 64, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("init_req_held",  int'(bus.gain_wr_req),  1);
    check("init_data_held", int'(bus.gain_wr_data), 'h7F);
    ack_pulse();
    check("init_req_drop", int'(bus.gain_wr_req), 0);
    check("init_settling", int'(bus.settling),    1);
    wait_settle_done("init_settle");

    // In-range window, gain unchanged: strobe but no write.
    push(EV_TBL, 100, 120);
    window(100, 120);
    repeat (4) tick();
    check("w1_no_req", int'(bus.gain_wr_req), 0);

    // Gapped window with truncating average; table steps vga 31->30.
    bus.gain_in = 7'h7E;
    push(EV_TBL, 4, 200);
    push(EV_WR, 'h7E, 0);
    push(EV_SET, 64, 0);
    for (int i = 1; i <= 8; i++) begin
      sample(i, 200);
      if (i < 8) tick();
    end
    check("w2_eval_table_en", int'(bus.table_en),    1);
    check("w2_eval_req",      int'(bus.gain_wr_req), 0);
    tick();
    check("w2_check_req", int'(bus.gain_wr_req), 0);
    tick();
    check("w2_write_req",  int'(bus.gain_wr_req),  1);
    check("w2_write_data", int'(bus.gain_wr_data), 'h7E);

    // Samples streamed through WRITE and SETTLE must be discarded.
    bus.sample_valid = 1'b1;
    bus.rssi_in      = 8'd255;
    bus.pwr_in       = 8'd255;
    repeat (3) tick();
    check("w2_req_stable", int'(bus.gain_wr_data), 'h7E);
    bus.gain_wr_ack = 1'b1;
    tick();
    bus.gain_wr_ack = 1'b0;
    wait_settle_done("w2_settle");
    bus.sample_valid = 1'b0;

    push(EV_TBL, 10, 10);
    window(10, 10);
    repeat (4) tick();
    check("w3_no_req", int'(bus.gain_wr_req), 0);

    // Frozen window: averages update, no strobe, no write.
    bus.freeze = 1'b1;
    window(40, 50);
    check("frz_rssi_avg", int'(bus.rssi_avg), 40);
    check("frz_pwr_avg",  int'(bus.pwr_avg),  50);
    check("frz_table_en", int'(bus.table_en), 0);
    repeat (3) tick();
    check("frz_no_req", int'(bus.gain_wr_req), 0);
    bus.freeze = 1'b0;

    push(EV_TBL, 255, 0);
    window(255, 0);
    repeat (4) tick();
    check("w5_no_req", int'(bus.gain_wr_req), 0);

    // Reset during an un-acked write re-issues the reset gain.
    bus.gain_in = 7'h7D;
    push(EV_TBL, 20, 30);
    window(20, 30);
    wait_req("rw_req");
    check("rw_data", int'(bus.gain_wr_data), 'h7D);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.gain_in = 7'h7F;
    check("rw_rst_req",      int'(bus.gain_wr_req),  1);
    check("rw_rst_data",     int'(bus.gain_wr_data), 'h7F);
    check("rw_rst_rssi_avg", int'(bus.rssi_avg),     0);
    push(EV_WR, 'h7F, 0);
    push(EV_SET, 64, 0);
    repeat (2) tick();
    ack_pulse();
    wait_settle_done("rw_settle");

    push(EV_TBL, 16, 32);
    window(16, 32);
    repeat (4) tick();
    check("w6_no_req", int'(bus.gain_wr_req), 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/agc_sequencer.md
Name: agc_sequencer

Overview:
- Sequences the AGC gain table in the receive chain.
- Averages incoming RSSI and power samples over a fixed window, then pulses the table enable once per window.
- Pushes any resulting gain change to the radio front-end through a req/ack write port, then blanks measurements for a settle interval.
- Sits between the RSSI/power estimators, the gain table, and the radio control interface.

Parameters:
AVG_LOG2, 3, log2 of samples per averaging window (window = 8)
SETTLE_CYCLES, 64, clk cycles to ignore samples after a gain write; must be >= 1
SETTLE_W, 8, width of settle counter; must hold SETTLE_CYCLES-1
INIT_GAIN, 7'h7F, gain assumed at reset; matches table reset {lna=3, vga=31}

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  rssi_in/pwr_in valid this cycle
rssi_in  in  8  unsigned RSSI sample
pwr_in  in  8  unsigned baseband power sample
freeze  in  1  high = do not update gain (packet in progress)
gain_in  in  7  current gain from table {lna[1:0], vga[4:0]}
table_en  out  1  one-cycle enable to gain table
rssi_avg  out  8  last window RSSI average, drives table rssi_in
pwr_avg  out  8  last window power average, drives table pwr_in
gain_wr_req  out  1  gain write request to radio control
gain_wr_data  out  7  gain value being written
gain_wr_ack  in  1  radio control accepted the write
settling  out  1  high while in SETTLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high, named reset; the clock is clk.
- Reset values:
  - state = WRITE; gain_wr_req = 1; gain_wr_data = INIT_GAIN; last_gain = INIT_GAIN
  - table_en = 0; rssi_avg = 0; pwr_avg = 0; settling = 0
  - sums and sample count = 0
- States: ACCUM, EVAL, CHECK, WRITE, SETTLE.
- ACCUM:
  - On each sample_valid, add to rssi_sum and pwr_sum (each 8+AVG_LOG2 bits; no overflow possible) and increment cnt.
  - When the sample that makes cnt = 2^AVG_LOG2 arrives, that sample is included. Next cycle: rssi_avg = rssi_sum>>AVG_LOG2 and pwr_avg likewise (truncated, full window); sums and cnt cleared.
  - If freeze=1 in the completing cycle, stay in ACCUM (averages still update). Else go to EVAL.
  - freeze never stalls accumulation.
- EVAL: table_en=1 for exactly this one cycle (averages are already stable); go to CHECK.
- CHECK:
  - The table output has updated. If gain_in != last_gain: latch gain_wr_data = gain_in, assert gain_wr_req, go to WRITE. Else go to ACCUM.
  - freeze is not re-checked here.
- WRITE:
  - gain_wr_req and gain_wr_data are held stable until gain_wr_ack.
  - In the ack cycle: last_gain = gain_wr_data. Next cycle: req = 0, settle counter loaded with SETTLE_CYCLES-1, go to SETTLE.
  - An ack already high on entry completes in the first WRITE cycle.
  - gain_wr_ack outside WRITE is ignored.
  - freeze does not abort a write.
- SETTLE:
  - settling = 1. Decrement the counter each cycle; at 0 go to ACCUM with sums and count cleared.
  - Settle duration is exactly SETTLE_CYCLES cycles.
- sample_valid is ignored in EVAL, CHECK, WRITE and SETTLE; partial windows are never used.
- Assertion of reset in any state (including mid-WRITE with req high) returns to the reset values next cycle. The initial write of INIT_GAIN is re-issued.
- Worst-case latency from the last window sample to req: 3 cycles (ACCUM→EVAL→CHECK→WRITE).

Test Plan:
- Reset release, ack after 5 cycles:
  - Expect req=1 with data=7'h7F from the first cycle; req drops the cycle after ack.
  - Expect settling high for exactly 64 cycles, then ACCUM.
- Eight valid samples after settle: rssi=100, pwr=120 (table holds gain, in-range):
  - Expect avg=100/120 one cycle after the 8th sample, then one table_en pulse, then no req.
- Eight samples with pwr=200 and table stepping vga 31→30:
  - Expect table_en, then req with data=7'h7E two cycles after table_en.
  - On ack: last_gain=7'h7E, then 64-cycle settle.
- freeze=1 across a completed window of pwr=50:
  - Averages update to 50; table_en stays 0; no req; the next window accumulates normally.
- sample_valid pulsed continuously during WRITE and SETTLE, then 8 samples of value 10 after settle:
  - Averages = 10; samples from blanked states are not included.
- reset asserted while req=1 and before ack:
  - Next cycle data=7'h7F, req=1, sums=0; a later ack leads into a normal settle.
